// File: rtl/seg_pkg.sv
// Shared constants for the result display: FSM state codes and active-low 7-segment patterns.
package seg_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE    = 2'd0;
   localparam state_t ST_CONVERT = 2'd1;
   localparam state_t ST_ENCODE  = 2'd2;
   localparam state_t ST_COMMIT  = 2'd3;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_DASH  = 7'h3F;

   // Active-low, bit0 = a ... bit6 = g, indexed by hex digit value.
   localparam logic [6:0] SEG_CODE [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

endpackage

// File: rtl/hex_to_seg.sv
// Combinational 4-bit to active-low 7-segment decoder.
module hex_to_seg
   import seg_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   assign seg = SEG_CODE[nibble];

endmodule

// File: rtl/seg_result_display.sv
// Result display stage: handshake in a value, encode one digit per cycle into a shadow bank, commit atomically.
// Build option: define SEG_DECIMAL_EN for decimal display (double-dabble CONVERT state); default is hex.
module seg_result_display
   import seg_pkg::*;
#(
   parameter int DATA_W     = 24,
   parameter int NUM_DIGITS = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              show,
   output logic              done,
   output logic              busy,
   output logic [6:0]        HEX0,
   output logic [6:0]        HEX1,
   output logic [6:0]        HEX2,
   output logic [6:0]        HEX3,
   output logic [6:0]        HEX4,
   output logic [6:0]        HEX5
);

   localparam int HW    = 4 * NUM_DIGITS;
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

   state_t           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [HW-1:0]    digits_q, digits_d;   // hex nibbles or BCD digits, digit 0 in the LSBs
   logic [6:0]       shadow_q [NUM_DIGITS];
   logic [6:0]       shadow_d [NUM_DIGITS];
   logic [6:0]       disp_q   [NUM_DIGITS];
   logic [6:0]       disp_d   [NUM_DIGITS];
   logic [3:0]       nib;
   logic [6:0]       nib_seg, enc_seg;

`ifdef SEG_DECIMAL_EN
   localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

   logic [DATA_W-1:0] bin_q, bin_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              ovf_q, ovf_d;
   logic [HW-1:0]     adj;

   // Add-3 correction; a 1 shifted out of the top digit means the value needs more digits than we have.
   always_comb begin
      adj = digits_q;
      for (int d = 0; d < NUM_DIGITS; d++) begin
         if (digits_q[4*d +: 4] >= 4'd5) adj[4*d +: 4] = digits_q[4*d +: 4] + 4'd3;
      end
   end
`else
   logic [HW-1:0] ext;

   if (DATA_W >= HW) begin : g_trunc
      assign ext = in_data[HW-1:0];
   end else begin : g_zext
      assign ext = {{(HW - DATA_W){1'b0}}, in_data};
   end
`endif

   always_comb begin
      nib = 4'd0;
      for (int d = 0; d < NUM_DIGITS; d++) begin
         if (idx_q == IDX_W'(d)) nib = digits_q[4*d +: 4];
      end
   end

   hex_to_seg u_hex_to_seg (
      .nibble (nib),
      .seg    (nib_seg)
   );

`ifdef SEG_DECIMAL_EN
   assign enc_seg = ovf_q ? SEG_DASH : nib_seg;
`else
   assign enc_seg = nib_seg;
`endif

   // NOTE: every variable gets its hold value first, so no path through the case can infer a latch.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      digits_d = digits_q;
      shadow_d = shadow_q;
      disp_d   = disp_q;
`ifdef SEG_DECIMAL_EN
      bin_d    = bin_q;
      cnt_d    = cnt_q;
      ovf_d    = ovf_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               idx_d = '0;
`ifdef SEG_DECIMAL_EN
               bin_d    = in_data;
               digits_d = '0;
               cnt_d    = '0;
               ovf_d    = 1'b0;
               state_d  = ST_CONVERT;
`else
               digits_d = ext;
               state_d  = ST_ENCODE;
`endif
            end
         end
`ifdef SEG_DECIMAL_EN
         ST_CONVERT: begin
            digits_d = {adj[HW-2:0], bin_q[DATA_W-1]};
            ovf_d    = ovf_q | adj[HW-1];
            bin_d    = bin_q << 1;
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_CNT) state_d = ST_ENCODE;
         end
`endif
         ST_ENCODE: begin
            shadow_d[idx_q] = enc_seg;
            idx_d           = idx_q + IDX_W'(1);
            if (idx_q == LAST_IDX) state_d = ST_COMMIT;
         end
         ST_COMMIT: begin
            disp_d  = shadow_q;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: both digit banks are reset explicitly so the display powers up blank, not random segments.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         idx_q    <= '0;
         digits_q <= '0;
         for (int i = 0; i < NUM_DIGITS; i++) begin
            shadow_q[i] <= SEG_BLANK;
            disp_q[i]   <= SEG_BLANK;
         end
`ifdef SEG_DECIMAL_EN
         bin_q <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         digits_q <= digits_d;
         shadow_q <= shadow_d;
         disp_q   <= disp_d;
`ifdef SEG_DECIMAL_EN
         bin_q <= bin_d;
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
`endif
      end
   end

   assign in_ready = (state_q == ST_IDLE);
   assign busy     = (state_q != ST_IDLE);
   assign done     = (state_q == ST_COMMIT);

   assign HEX0 = show ? disp_q[0] : SEG_BLANK;
   assign HEX1 = show ? disp_q[1] : SEG_BLANK;
   assign HEX2 = show ? disp_q[2] : SEG_BLANK;
   assign HEX3 = show ? disp_q[3] : SEG_BLANK;
   assign HEX4 = show ? disp_q[4] : SEG_BLANK;
   assign HEX5 = show ? disp_q[5] : SEG_BLANK;

endmodule

// File: tb/tb_seg_result_display.sv
// Self-checking bench for seg_result_display: directed plan cases plus randomized values against a digit-arithmetic model.
module tb_seg_result_display;

   localparam int DATA_W = 24;
   localparam int ND     = 6;
`ifdef SEG_DECIMAL_EN
   localparam int LAT = DATA_W + ND + 1;
`else
   localparam int LAT = ND + 1;
`endif

   localparam logic [6:0] REF_CODE [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   logic              clk;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              show;
   logic              done;
   logic              busy;
   logic [6:0]        HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
   logic [6:0]        hex_o [ND];
   logic [6:0]        exp_disp [ND];

   int checks = 0;
   int errors = 0;

   seg_result_display #(.DATA_W(DATA_W), .NUM_DIGITS(ND)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .show     (show),
      .done     (done),
      .busy     (busy),
      .HEX0     (HEX0),
      .HEX1     (HEX1),
      .HEX2     (HEX2),
      .HEX3     (HEX3),
      .HEX4     (HEX4),
      .HEX5     (HEX5)
   );

   assign hex_o[0] = HEX0;
   assign hex_o[1] = HEX1;
   assign hex_o[2] = HEX2;
   assign hex_o[3] = HEX3;
   assign hex_o[4] = HEX4;
   assign hex_o[5] = HEX5;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %02h expected %02h", tag, got, exp);
      end
   endtask

   // Expected segment pattern of digit n for value v, straight from the display rules.
   function automatic logic [6:0] ref_digit(input int unsigned v, input int n);
      int unsigned d;
`ifdef SEG_DECIMAL_EN
      int unsigned p = 1;
      if (v > 999999) return 7'h3F;
      for (int i = 0; i < n; i++) p = p * 10;
      d = (v / p) % 10;
`else
      d = (v >> (4 * n)) & 32'hF;
`endif
      return REF_CODE[d[3:0]];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_display(input string tag);
      for (int n = 0; n < ND; n++) check(tag, hex_o[n], exp_disp[n]);
   endtask

   task automatic wait_ready();
      int k = 0;
      while (!in_ready && k < 100) begin
         tick();
         k++;
      end
      check("ready_wait", 7'(in_ready), 7'd1);
   endtask

   // Presents v (in_ready must be high), follows it to commit; with hold, keeps in_valid up carrying nxt.
   task automatic transfer(input logic [DATA_W-1:0] v, input bit hold, input logic [DATA_W-1:0] nxt);
      in_valid = 1'b1;
      in_data  = v;
      tick();
      if (hold) in_data = nxt;
      else begin
         in_valid = 1'b0;
         in_data  = DATA_W'($urandom);
      end
      for (int k = 1; k < LAT; k++) begin
         tick();
         check("busy_during", 7'(busy), 7'd1);
         check("ready_during", 7'(in_ready), 7'd0);
         check("done_timing", 7'(done), (k == LAT - 1) ? 7'd1 : 7'd0);
         check_display("no_torn");
      end
      tick();
      for (int n = 0; n < ND; n++) exp_disp[n] = ref_digit(int'(v), n);
      check_display("committed");
      check("ready_after", 7'(in_ready), 7'd1);
      check("done_after", 7'(done), 7'd0);
   endtask

   initial begin
      logic [DATA_W-1:0] v;
      rst      = 1'b1;
      in_valid = 1'b0;
      in_data  = '0;
      show     = 1'b1;
      for (int n = 0; n < ND; n++) exp_disp[n] = 7'h7F;
      tick();
      tick();
      rst = 1'b0;
      check_display("reset_blank");
      check("reset_ready", 7'(in_ready), 7'd1);
      check("reset_busy", 7'(busy), 7'd0);
      check("reset_done", 7'(done), 7'd0);

`ifdef SEG_DECIMAL_EN
      wait_ready(); transfer(24'd7000, 1'b0, '0);
      wait_ready(); transfer(24'd1000000, 1'b0, '0);
      wait_ready(); transfer(24'd999999, 1'b0, '0);
      wait_ready(); transfer(24'd0, 1'b0, '0);
      wait_ready(); transfer(24'd7000, 1'b0, '0);
`else
      wait_ready(); transfer(24'h001B58, 1'b0, '0);
      check("hex5_1b58", HEX5, 7'h40);
      check("hex0_1b58", HEX0, 7'h00);
      wait_ready(); transfer(24'hFFFFFF, 1'b0, '0);
      wait_ready(); transfer(24'h000000, 1'b0, '0);
      wait_ready(); transfer(24'h001B58, 1'b0, '0);
`endif

      // Show gating is combinational: no clock edge between the change and the sample.
      show = 1'b0;
      #1;
      for (int n = 0; n < ND; n++) check("show_off", hex_o[n], 7'h7F);
      show = 1'b1;
      #1;
      check_display("show_on");

      wait_ready();
      transfer(24'hABCDEF, 1'b1, 24'h123456);
      transfer(24'h123456, 1'b0, '0);
`ifndef SEG_DECIMAL_EN
      check("bp_hex5", HEX5, 7'h79);
      check("bp_hex0", HEX0, 7'h02);
`endif

      for (int r = 0; r < 10; r++) begin
         repeat ($urandom_range(0, 3)) tick();
`ifdef SEG_DECIMAL_EN
         v = ($urandom_range(0, 1) == 1) ? DATA_W'($urandom_range(0, 999999)) : DATA_W'($urandom);
`else
         v = DATA_W'($urandom);
`endif
         wait_ready();
         transfer(v, 1'b0, '0);
      end

      wait_ready();
      in_valid = 1'b1;
      in_data  = 24'hFFFFFF;
      tick();
      in_valid = 1'b0;
      repeat (LAT - 4) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int n = 0; n < ND; n++) exp_disp[n] = 7'h7F;
      check_display("midrst_blank");
      check("midrst_ready", 7'(in_ready), 7'd1);
      check("midrst_busy", 7'(busy), 7'd0);
      check("midrst_done", 7'(done), 7'd0);
      for (int k = 0; k < LAT + 2; k++) begin
         tick();
         check("midrst_nodone", 7'(done), 7'd0);
         check_display("midrst_stay");
      end

      wait_ready();
      transfer(DATA_W'(24'h054321), 1'b0, '0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
